// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver: synchronises rx_i, samples each bit at mid-bit and
// presents each received byte on an AXI-Stream master with error/overrun pulses.
module uart_rx_axis #(
  parameter int unsigned CLKS_PER_BIT = 280
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] m_axis_tdata_o,
  output logic       m_axis_tvalid_o,
  input  logic       m_axis_tready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  logic [1:0]    r_sync;
  logic          w_rx_s;

  state_e        r_state,     w_state_d;
  logic [TW-1:0] r_timer,     w_timer_d;
  logic [2:0]    r_idx,       w_idx_d;
  logic [7:0]    r_shreg,     w_shreg_d;
  logic          r_armed,     w_armed_d;
  logic [7:0]    r_tdata,     w_tdata_d;
  logic          r_tvalid,    w_tvalid_d;
  logic          r_frame_err, w_frame_err_d;
  logic          r_overrun,   w_overrun_d;

  // Reset: asserts asynchronously, releases on a clock edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Two-flop synchroniser on the asynchronous line; idle level is high
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx_i};
    end
  end

  assign w_rx_s = r_sync[1];

  // State register and all registered outputs
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_idx       <= '0;
      r_shreg     <= '0;
      r_armed     <= 1'b1;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_timer     <= w_timer_d;
      r_idx       <= w_idx_d;
      r_shreg     <= w_shreg_d;
      r_armed     <= w_armed_d;
      r_tdata     <= w_tdata_d;
      r_tvalid    <= w_tvalid_d;
      r_frame_err <= w_frame_err_d;
      r_overrun   <= w_overrun_d;
    end
  end

  // Next-state, bit timing, deserialisation and stream handshake
  always_comb begin
    w_state_d     = r_state;
    w_timer_d     = r_timer;
    w_idx_d       = r_idx;
    w_shreg_d     = r_shreg;
    w_armed_d     = r_armed;
    w_tdata_d     = r_tdata;
    w_tvalid_d    = r_tvalid && !m_axis_tready_i;
    w_frame_err_d = 1'b0;
    w_overrun_d   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_timer_d = '0;
        if (w_rx_s) begin
          w_armed_d = 1'b1;
        end else if (r_armed) begin
          w_state_d = S_START;
        end
      end

      S_START: begin
        if (r_timer == HALF_M1) begin
          w_timer_d = '0;
          if (!w_rx_s) begin
            w_state_d = S_DATA;
            w_idx_d   = '0;
          end else begin
            w_state_d = S_IDLE;
          end
        end else begin
          w_timer_d = r_timer + TW'(1);
        end
      end

      S_DATA: begin
        if (r_timer == FULL_M1) begin
          w_timer_d          = '0;
          w_shreg_d[r_idx]   = w_rx_s;
          if (r_idx == 3'd7) begin
            w_state_d = S_STOP;
          end else begin
            w_idx_d = r_idx + 3'd1;
          end
        end else begin
          w_timer_d = r_timer + TW'(1);
        end
      end

      S_STOP: begin
        if (r_timer == FULL_M1) begin
          w_timer_d = '0;
          w_state_d = S_IDLE;
          if (w_rx_s) begin
            // A byte may replace one that is being accepted this same cycle
            if (!r_tvalid || m_axis_tready_i) begin
              w_tdata_d  = r_shreg;
              w_tvalid_d = 1'b1;
            end else begin
              w_overrun_d = 1'b1;
            end
          end else begin
            w_frame_err_d = 1'b1;
            w_armed_d     = 1'b0;
          end
        end else begin
          w_timer_d = r_timer + TW'(1);
        end
      end

      default: begin
        w_state_d = S_IDLE;
        w_timer_d = '0;
      end
    endcase
  end

  assign m_axis_tdata_o  = r_tdata;
  assign m_axis_tvalid_o = r_tvalid;
  assign frame_err_o     = r_frame_err;
  assign overrun_o       = r_overrun;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed and randomised bench for uart_rx_axis: serialises bytes onto rx_i
// and compares received beats and flag pulses against expectations.
module tb_uart_rx_axis;

  localparam int unsigned CPB = 280;
  localparam int unsigned LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx     = 1'b1;
  logic       tready = 1'b0;
  logic [7:0] tdata;
  logic       tvalid;
  logic       fe;
  logic       ov;

  uart_rx_axis #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .rx_i            (rx),
    .m_axis_tdata_o  (tdata),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tready_i (tready),
    .frame_err_o     (fe),
    .overrun_o       (ov)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: accepted beats, flag pulses and protocol violations
  logic [7:0]  beats[$];
  int          fe_cnt = 0, ov_cnt = 0, both_cnt = 0, wide_cnt = 0, unstable_cnt = 0;
  int unsigned rise_cyc = 0;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_fe = 1'b0, p_ov = 1'b0;
  logic [7:0]  p_data = 8'h00;

  always @(negedge clk) begin
    if (tvalid && tready) beats.push_back(tdata);
    if (fe) fe_cnt++;
    if (ov) ov_cnt++;
    if (fe && ov) both_cnt++;
    if ((fe && p_fe) || (ov && p_ov)) wide_cnt++;
    if (p_valid && !p_ready && tvalid && (tdata !== p_data)) unstable_cnt++;
    if (tvalid && !p_valid) rise_cyc = cyc;
    p_valid = tvalid;
    p_ready = tready;
    p_fe    = fe;
    p_ov    = ov;
    p_data  = tdata;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          rd = 0;
  int unsigned t_start = 0;
  int          fe0, ov0, fe_exp;
  logic [7:0]  exp_q[$];
  logic [7:0]  rb;
  logic        rstop;
  int unsigned lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] expv);
    logic [31:0] o;
    o = (rd < beats.size()) ? 32'(beats[rd]) : 32'hDEAD;
    chk(tag, o, 32'(expv));
    rd++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One 10-bit frame; optional random tready per cycle or a one-cycle tready pulse
  task automatic send(input logic [7:0] b, input logic stop, input bit rnd_rdy, input int rdy_at);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10 * int'(CPB); i++) begin
      tick();
      rx = f[i / int'(CPB)];
      if (i == 0) t_start = cyc;
      if (rnd_rdy) tready = 1'($urandom_range(0, 1));
      if (rdy_at >= 0) begin
        if (i == rdy_at) tready = 1'b1;
        else if (i == rdy_at + 1) tready = 1'b0;
      end
    end
  endtask

  initial begin
    idle(5);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    chk("rst_frame_err", 32'(fe), 32'd0);
    chk("rst_overrun", 32'(ov), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Single byte with consumer always ready; latency from start edge
    tready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send(8'h41, 1'b1, 1'b0, -1);
    idle(CPB);
    chk_beat("t1_beat", 8'h41);
    lat = rise_cyc - t_start;
    chk("t1_latency_window", 32'(lat + 1 >= LAT && lat <= LAT + 1), 32'd1);
    chk("t1_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("t1_ov", 32'(ov_cnt - ov0), 32'd0);

    // Consumer stalled: second byte overruns, first is held
    tready = 1'b0;
    ov0 = ov_cnt;
    send(8'h55, 1'b1, 1'b0, -1);
    send(8'hAA, 1'b1, 1'b0, -1);
    idle(CPB);
    chk("t2_tvalid_held", 32'(tvalid), 32'd1);
    chk("t2_tdata_held", 32'(tdata), 32'h55);
    chk("t2_overrun", 32'(ov_cnt - ov0), 32'd1);
    chk("t2_no_beat_yet", 32'(beats.size()), 32'(rd));
    tick();
    tready = 1'b1;
    tick();
    tready = 1'b0;
    idle(3);
    chk_beat("t2_beat", 8'h55);
    chk("t2_tvalid_clr", 32'(tvalid), 32'd0);
    chk("t2_single_beat", 32'(beats.size()), 32'(rd));

    // Short low glitch is rejected, then a clean byte
    tready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx = 1'b0;
    idle(50);
    rx = 1'b1;
    idle(2 * CPB);
    chk("t3_no_beat", 32'(beats.size()), 32'(rd));
    chk("t3_no_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    send(8'h3C, 1'b1, 1'b0, -1);
    idle(CPB);
    chk_beat("t3_beat", 8'h3C);

    // Bad stop bit with line held low: a single framing error
    fe0 = fe_cnt;
    send(8'h5A, 1'b0, 1'b0, -1);
    idle(3000);
    chk("t4_one_frame_err", 32'(fe_cnt - fe0), 32'd1);
    chk("t4_no_beat", 32'(beats.size()), 32'(rd));
    rx = 1'b1;
    idle(CPB);
    tready = 1'b0;
    send(8'h7E, 1'b1, 1'b0, -1);
    idle(CPB);
    chk("t4_tvalid", 32'(tvalid), 32'd1);
    chk("t4_tdata", 32'(tdata), 32'h7E);

    // Reset in the middle of data bit 3
    rx = 1'b0;
    idle(CPB);
    rx = 1'b1; idle(CPB);
    rx = 1'b0; idle(CPB);
    rx = 1'b1; idle(CPB);
    rx = 1'b0; idle(CPB / 2);
    #2;
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    chk("t5_async_tvalid", 32'(tvalid), 32'd0);
    chk("t5_async_tdata", 32'(tdata), 32'd0);
    chk("t5_async_flags", 32'({fe, ov}), 32'd0);
    idle(10);
    rst_n = 1'b1;
    idle(2 * CPB);
    chk("t5_no_partial", 32'(tvalid), 32'd0);
    tready = 1'b1;
    send(8'hC3, 1'b1, 1'b0, -1);
    idle(CPB);
    chk_beat("t5_beat", 8'hC3);
    chk("t5_beat_count", 32'(beats.size()), 32'(rd));

    // Back-to-back with tready only on the second stop-sample cycle
    tready = 1'b0;
    ov0 = ov_cnt;
    send(8'h00, 1'b1, 1'b0, -1);
    send(8'hFF, 1'b1, 1'b0, int'(LAT) - 1);
    chk("t6_tvalid", 32'(tvalid), 32'd1);
    chk("t6_tdata", 32'(tdata), 32'hFF);
    chk("t6_no_overrun", 32'(ov_cnt - ov0), 32'd0);
    tready = 1'b1;
    idle(5);
    chk_beat("t6_beat0", 8'h00);
    chk_beat("t6_beat1", 8'hFF);
    chk("t6_tvalid_clr", 32'(tvalid), 32'd0);

    // Random bytes, random stop errors, random consumer stalls
    fe0 = fe_cnt; ov0 = ov_cnt; fe_exp = 0;
    for (int n = 0; n < 6; n++) begin
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      send(rb, rstop, 1'b1, -1);
      if (rstop) begin
        exp_q.push_back(rb);
        idle(int'($urandom_range(0, CPB)));
      end else begin
        fe_exp++;
        rx = 1'b1;
        idle(int'(CPB) + int'($urandom_range(0, CPB)));
      end
    end
    tready = 1'b1;
    idle(10);
    foreach (exp_q[k]) chk_beat($sformatf("rnd_beat%0d", k), exp_q[k]);
    chk("rnd_beat_count", 32'(beats.size()), 32'(rd));
    chk("rnd_frame_errs", 32'(fe_cnt - fe0), 32'(fe_exp));
    chk("rnd_overruns", 32'(ov_cnt - ov0), 32'd0);

    chk("flags_never_both", 32'(both_cnt), 32'd0);
    chk("flags_one_cycle", 32'(wide_cnt), 32'd0);
    chk("tdata_stable_stalled", 32'(unstable_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
